vram_port_arbiter: RTL and testbench
====================================

VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning); ports, one per line (name, direction, width, meaning):
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 10, RAM port-B address width; word count = 2**ADDR_WIDTH.
- CLK_50, in, 1, single clock; RAM port B is clocked by the same clock.
- reset, in, 1, asynchronous, active-high.
- vga_active, in, 1, VGA needs port B this cycle.
- vga_addr, in, ADDR_WIDTH, VGA word address.
- vga_data, out, DATA_WIDTH, RAM read data for VGA.
- clear_start, in, 1, one-cycle pulse requesting a full RAM clear.
- clear_busy, out, 1, clear in progress.
- clear_done, out, 1, one-cycle pulse when the clear completes.
- dbg_req, in, 1, debug read request; held until dbg_ack.
- dbg_addr, in, ADDR_WIDTH, debug read address; stable while dbg_req is high.
- dbg_ack, out, 1, one-cycle pulse; dbg_data valid in the same cycle.
- dbg_data, out, DATA_WIDTH, captured debug read word.
- ram_addr_b, out, ADDR_WIDTH, RAM port-B address.
- ram_data_b, out, DATA_WIDTH, RAM port-B write data (always zero).
- ram_wren_b, out, 1, RAM port-B write enable.
- ram_q_b, in, DATA_WIDTH, RAM port-B read data; valid 1 cycle after address.
REQ-002 The clock is CLK_50; reset is asynchronous and active-high; no other clock or reset exists.

Function
REQ-003 Fixed priority per cycle: VGA > clear engine > debug read; exactly one requester owns port B each cycle.
REQ-004 While vga_active=1: ram_addr_b=vga_addr, ram_wren_b=0; the clear and debug engines stall and hold their state.
REQ-005 vga_data SHALL equal ram_q_b combinationally; the VGA sees one-cycle read latency.
REQ-006 FSM states: IDLE, CLEAR, DBG_RD, DBG_CAP.
REQ-007 IDLE: clear_start=1 -> CLEAR with counter=0 and clear_busy=1. Else dbg_req=1 and no pending ack -> DBG_RD.
REQ-008 If clear_start and dbg_req are both high in IDLE, clear wins; the debug request waits.
REQ-009 CLEAR, granted cycle (vga_active=0): ram_addr_b=counter, ram_data_b=0, ram_wren_b=1, counter+1.
REQ-010 CLEAR, stalled cycle: ram_wren_b=0 and the counter holds.
REQ-011 After the write to address 2**ADDR_WIDTH-1, the next cycle is IDLE: clear_busy=0, clear_done=1 for exactly one cycle. The counter wraps to 0 and does not overrun.
REQ-012 clear_start while clear_busy=1 is ignored; the clear does not restart.
REQ-013 DBG_RD, granted cycle: ram_addr_b=dbg_addr, ram_wren_b=0 -> DBG_CAP. A stalled DBG_RD stays in DBG_RD.
REQ-014 DBG_CAP: dbg_data<=ram_q_b is captured unconditionally, even if vga_active=1, because the data belongs to the previous cycle. Next cycle dbg_ack=1 for one cycle, then IDLE.
REQ-015 Minimum debug latency: 3 cycles from dbg_req rising in IDLE to dbg_ack.
REQ-016 dbg_data holds its value until the next capture.
REQ-017 Idle port B (no grant): ram_addr_b=0, ram_wren_b=0, ram_data_b=0.

Reset
REQ-018 Asserted reset: FSM=IDLE, counter=0, clear_busy=0, clear_done=0, dbg_ack=0, dbg_data=0, ram_wren_b=0.
REQ-019 Reset mid-clear or mid-debug aborts the operation immediately with no clear_done or dbg_ack pulse.

Configuration
REQ-020 Macro VRAM_ARB_CLEAR_ON_RESET_EN.
- Defined: the first clock edge after reset deasserts enters CLEAR as if clear_start had pulsed, so a full clear runs at power-up.
- Undefined: the block stays in IDLE until clear_start.
- All other behaviour is identical in both builds.

Verification
REQ-021 ADDR_WIDTH=4, clear_start pulse, vga_active=0 -> 16 consecutive writes to addresses 0..15 with data 0, clear_done at cycle 17, clear_busy low afterwards.
REQ-022 Clear running, vga_active=1 for cycles 5..9 -> writes pause for exactly 5 cycles with no address skipped or repeated; clear_done 5 cycles later than in REQ-021.
REQ-023 RAM word 0x3=0xBEEF, dbg_req with dbg_addr=3, vga_active=0 -> dbg_ack 3 cycles later with dbg_data=0xBEEF.
REQ-024 Same stimulus as REQ-023 with vga_active=1 in the DBG_CAP cycle -> dbg_data still 0xBEEF; with vga_active=1 in the DBG_RD cycle -> the read is delayed.
REQ-025 clear_start and dbg_req in the same cycle -> the clear completes first, then dbg_ack follows.
REQ-026 reset at clear counter=7 -> no clear_done, outputs at reset values. With VRAM_ARB_CLEAR_ON_RESET_EN defined, a new clear starts at address 0 after reset release.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Port-B arbiter for the video RAM: VGA scan-out, a full-RAM clear engine and a debug reader.
// Optional macro VRAM_ARB_CLEAR_ON_RESET_EN starts a clear on the first edge after reset.
module vram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK_50,
    input  logic                  reset,
    input  logic                  vga_active,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic [DATA_WIDTH-1:0] vga_data,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  ram_wren_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    typedef enum logic [1:0] {IDLE, CLEAR, DBG_RD, DBG_CAP} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  done_nxt, ack_nxt, cap;
    logic                  start_clr;

`ifdef VRAM_ARB_CLEAR_ON_RESET_EN
    // Set while in reset, so the first edge after release behaves like a clear_start pulse.
    logic boot_clr;
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) boot_clr <= 1'b1;
        else       boot_clr <= 1'b0;
    end
    assign start_clr = clear_start | boot_clr;
`else
    assign start_clr = clear_start;
`endif

    assign vga_data   = ram_q_b;
    assign ram_data_b = '0;
    assign clear_busy = (state == CLEAR);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        done_nxt   = 1'b0;
        ack_nxt    = 1'b0;
        cap        = 1'b0;
        ram_addr_b = '0;
        ram_wren_b = 1'b0;
        case (state)
            IDLE: begin
                if (start_clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else if (dbg_req && !dbg_ack) begin
                    state_nxt = DBG_RD;
                end
            end
            CLEAR: begin
                if (!vga_active) begin
                    ram_addr_b = cnt;
                    ram_wren_b = 1'b1;
                    cnt_nxt    = cnt + ADDR_WIDTH'(1);
                    if (cnt == {ADDR_WIDTH{1'b1}}) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            DBG_RD: begin
                if (!vga_active) begin
                    ram_addr_b = dbg_addr;
                    state_nxt  = DBG_CAP;
                end
            end
            DBG_CAP: begin
                // Read data belongs to last cycle's address, so capture even if VGA owns the port now.
                cap       = 1'b1;
                ack_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (vga_active) begin
            ram_addr_b = vga_addr;
            ram_wren_b = 1'b0;
        end
    end

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            clear_done <= 1'b0;
            dbg_ack    <= 1'b0;
            dbg_data   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            clear_done <= done_nxt;
            dbg_ack    <= ack_nxt;
            if (cap) dbg_data <= ram_q_b;
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with ADDR_WIDTH=4 and a one-cycle-latency RAM model.
module tb_vram_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          vga_active;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          clear_start, clear_busy, clear_done;
    logic          dbg_req, dbg_ack;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_data_b;
    logic          ram_wren_b;
    logic [DW-1:0] ram_q_b;

    logic          tb_wr;
    logic [AW-1:0] tb_wa;
    logic [DW-1:0] tb_wd;
    logic [DW-1:0] mem [16];

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    vram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK_50(clk), .reset(reset),
        .vga_active(vga_active), .vga_addr(vga_addr), .vga_data(vga_data),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
        .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b),
        .ram_q_b(ram_q_b)
    );

    always @(posedge clk) begin
        if (tb_wr)           mem[tb_wa] <= tb_wd;
        else if (ram_wren_b) mem[ram_addr_b] <= ram_data_b;
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_wr = 1'b1; tb_wa = a; tb_wd = d;
        tick;
        tb_wr = 1'b0;
    endtask

    task automatic fill;
        for (int i = 0; i < 16; i++) poke(AW'(i), 16'hA000 | 16'(i));
    endtask

    function automatic logic [DW-1:0] mem_or;
        logic [DW-1:0] r = '0;
        for (int i = 0; i < 16; i++) r |= mem[i];
        return r;
    endfunction

    initial begin
        reset = 1'b1; vga_active = 1'b0; vga_addr = '0; clear_start = 1'b0;
        dbg_req = 1'b0; dbg_addr = '0; tb_wr = 1'b0; tb_wa = '0; tb_wd = '0;
        tick; tick;
        #1;
        chk("rst_busy", 32'(clear_busy), 0);
        chk("rst_done", 32'(clear_done), 0);
        chk("rst_ack", 32'(dbg_ack), 0);
        chk("rst_dbg_data", 32'(dbg_data), 0);
        chk("rst_wren", 32'(ram_wren_b), 0);
        chk("rst_addr", 32'(ram_addr_b), 0);
        reset = 1'b0;
`ifdef VRAM_ARB_CLEAR_ON_RESET_EN
        repeat (20) tick;
`endif

        // Full clear without VGA traffic; a second clear_start mid-run is ignored
        fill;
        clear_start = 1'b1;
        #1;
        chk("clr_idle_busy", 32'(clear_busy), 0);
        for (int i = 0; i < 16; i++) begin
            tick;
            clear_start = (i == 5);
            #1;
            chk("clr_wren", 32'(ram_wren_b), 1);
            chk("clr_addr", 32'(ram_addr_b), 32'(i));
            chk("clr_wdata", 32'(ram_data_b), 0);
            chk("clr_busy", 32'(clear_busy), 1);
            chk("clr_done_early", 32'(clear_done), 0);
        end
        tick; clear_start = 1'b0; #1;
        chk("clr_done", 32'(clear_done), 1);
        chk("clr_busy_end", 32'(clear_busy), 0);
        chk("clr_wren_end", 32'(ram_wren_b), 0);
        tick; #1;
        chk("clr_done_pulse", 32'(clear_done), 0);
        chk("clr_busy_stay", 32'(clear_busy), 0);
        chk("clr_mem_zero", 32'(mem_or()), 0);

        // Clear with VGA owning the port in cycles 5..9
        fill;
        clear_start = 1'b1;
        #1;
        begin
            int exp_a = 0;
            for (int c = 1; c <= 21; c++) begin
                tick;
                clear_start = 1'b0;
                vga_active = (c >= 5 && c <= 9);
                vga_addr = 4'hA;
                #1;
                if (vga_active) begin
                    chk("stall_wren", 32'(ram_wren_b), 0);
                    chk("stall_addr", 32'(ram_addr_b), 32'hA);
                end else begin
                    chk("stall_run_wren", 32'(ram_wren_b), 1);
                    chk("stall_run_addr", 32'(ram_addr_b), 32'(exp_a));
                    exp_a++;
                end
                if (c == 7) chk("vga_data", 32'(vga_data), 32'hA00A);
                chk("stall_done_early", 32'(clear_done), 0);
            end
        end
        tick; vga_active = 1'b0; #1;
        chk("stall_done", 32'(clear_done), 1);
        chk("stall_mem_zero", 32'(mem_or()), 0);

        // Debug read, no VGA
        poke(4'h3, 16'hBEEF);
        dbg_req = 1'b1; dbg_addr = 4'h3;
        #1;
        chk("dbg_c0_addr", 32'(ram_addr_b), 0);
        tick; #1;
        chk("dbg_c1_addr", 32'(ram_addr_b), 3);
        chk("dbg_c1_wren", 32'(ram_wren_b), 0);
        chk("dbg_c1_ack", 32'(dbg_ack), 0);
        tick; #1;
        chk("dbg_c2_ack", 32'(dbg_ack), 0);
        chk("dbg_c2_idle_addr", 32'(ram_addr_b), 0);
        tick; #1;
        chk("dbg_ack", 32'(dbg_ack), 1);
        chk("dbg_data", 32'(dbg_data), 32'hBEEF);
        dbg_req = 1'b0;
        tick; #1;
        chk("dbg_ack_pulse", 32'(dbg_ack), 0);
        chk("dbg_data_hold", 32'(dbg_data), 32'hBEEF);

        // VGA in the capture cycle does not disturb the captured word
        poke(4'h5, 16'h1234);
        dbg_req = 1'b1; dbg_addr = 4'h5;
        tick; #1;
        chk("cap_c1_addr", 32'(ram_addr_b), 5);
        tick; vga_active = 1'b1; vga_addr = 4'h3; #1;
        chk("cap_c2_vga_addr", 32'(ram_addr_b), 3);
        tick; vga_active = 1'b0; #1;
        chk("cap_ack", 32'(dbg_ack), 1);
        chk("cap_data", 32'(dbg_data), 32'h1234);
        dbg_req = 1'b0;
        tick;

        // VGA in the read cycle delays the read by one cycle
        poke(4'h6, 16'h5A5A);
        dbg_req = 1'b1; dbg_addr = 4'h6;
        tick; vga_active = 1'b1; vga_addr = 4'h3; #1;
        chk("rd_stall_addr", 32'(ram_addr_b), 3);
        tick; vga_active = 1'b0; #1;
        chk("rd_late_addr", 32'(ram_addr_b), 6);
        tick; #1;
        chk("rd_late_ack0", 32'(dbg_ack), 0);
        tick; #1;
        chk("rd_late_ack", 32'(dbg_ack), 1);
        chk("rd_late_data", 32'(dbg_data), 32'h5A5A);
        dbg_req = 1'b0;
        tick;

        // Clear and debug together: clear first, then the read sees zeroed RAM
        fill;
        clear_start = 1'b1; dbg_req = 1'b1; dbg_addr = 4'h7;
        #1;
        for (int c = 1; c <= 16; c++) begin
            tick; clear_start = 1'b0; #1;
            chk("both_clr_addr", 32'(ram_addr_b), 32'(c - 1));
            chk("both_ack0", 32'(dbg_ack), 0);
        end
        tick; #1;
        chk("both_done", 32'(clear_done), 1);
        chk("both_ack_c17", 32'(dbg_ack), 0);
        tick; #1;
        chk("both_rd_addr", 32'(ram_addr_b), 7);
        tick; #1;
        chk("both_ack_c19", 32'(dbg_ack), 0);
        tick; #1;
        chk("both_ack", 32'(dbg_ack), 1);
        chk("both_data", 32'(dbg_data), 0);
        dbg_req = 1'b0;
        tick;

        // Reset mid-clear at counter 7
        clear_start = 1'b1;
        #1;
        for (int c = 1; c <= 7; c++) begin
            tick; clear_start = 1'b0; #1;
        end
        tick; #1;
        chk("mid_addr7", 32'(ram_addr_b), 7);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(clear_busy), 0);
        chk("mid_rst_wren", 32'(ram_wren_b), 0);
        chk("mid_rst_addr", 32'(ram_addr_b), 0);
        chk("mid_rst_done", 32'(clear_done), 0);
        chk("mid_rst_ack", 32'(dbg_ack), 0);
        tick; tick;
        reset = 1'b0;
        tick; #1;
`ifdef VRAM_ARB_CLEAR_ON_RESET_EN
        chk("boot_busy", 32'(clear_busy), 1);
        chk("boot_addr", 32'(ram_addr_b), 0);
        chk("boot_wren", 32'(ram_wren_b), 1);
`else
        chk("post_rst_busy", 32'(clear_busy), 0);
        chk("post_rst_wren", 32'(ram_wren_b), 0);
`endif
        for (int c = 0; c < 4; c++) begin
            tick; #1;
            chk("post_rst_no_done", 32'(clear_done), 0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
